rps_game_fsm: RTL

Rock-paper-scissors game controller. It consumes decoded command bytes from the UART receiver and produces the `show`, `hand` and `score` signals that the VGA display stage renders. The machine's hand is drawn from a free-running mod-3 counter. A round steps through a "think" delay, then holds the result on screen until timeout, a clear command or a new play command. The block runs entirely in the 50 MHz system clock domain; the display stage samples its outputs as quasi-static levels.

---
 rtl/rps_game_fsm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rps_game_fsm.sv
// Rock-paper-scissors game controller.
// Decodes UART command bytes, runs a THINK / RESULT round with a shared
// down-counter, and drives registered show/hand/score levels for the
// display stage. The machine hand comes from a free-running mod-3 counter.
module rps_game_fsm #(
    parameter int unsigned THINK_CYC = 25_000_000,
    parameter int unsigned HOLD_CYC  = 150_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       show,
    output logic [3:0] hand,
    output logic [1:0] score
);

    // Hand encoding shared by player and machine.
    localparam logic [1:0] HAND_NONE     = 2'd0;
    localparam logic [1:0] HAND_ROCK     = 2'd1;
    localparam logic [1:0] HAND_SCISSORS = 2'd2;
    localparam logic [1:0] HAND_PAPER    = 2'd3;

    localparam logic [1:0] SCORE_PLAYER  = 2'd1;
    localparam logic [1:0] SCORE_MACHINE = 2'd2;
    localparam logic [1:0] SCORE_DRAW    = 2'd3;

    // Timer reload values: the transition fires when the counter reads 0,
    // so loading N-1 on entry gives exactly N cycles in the state.
    localparam logic [31:0] THINK_LOAD = 32'(THINK_CYC - 1);
    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_THINK  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_timer, w_timer_next;
    logic [1:0]  r_m_cnt, w_m_cnt_next;
    logic [1:0]  r_player, w_player_next;
    logic [1:0]  r_mach, w_mach_next;
    logic        r_show, w_show_next;
    logic [3:0]  r_hand, w_hand_next;
    logic [1:0]  r_score, w_score_next;

    logic        w_is_play;
    logic        w_is_clear;
    logic [1:0]  w_play_hand;
    logic [1:0]  w_outcome;
    logic        w_accept;
    logic        w_to_idle;
    logic        w_reveal;

    // Command decode: only a valid strobe with a recognised byte has any effect.
    always_comb begin
        w_play_hand = HAND_NONE;
        w_is_play   = 1'b0;
        w_is_clear  = 1'b0;
        if (rx_data_valid) begin
            case (rx_data)
                8'h52:   begin w_is_play = 1'b1; w_play_hand = HAND_ROCK;     end
                8'h53:   begin w_is_play = 1'b1; w_play_hand = HAND_SCISSORS; end
                8'h50:   begin w_is_play = 1'b1; w_play_hand = HAND_PAPER;    end
                8'h43:   w_is_clear = 1'b1;
                default: ;
            endcase
        end
    end

    // Outcome of the latched round: draw, player win or machine win.
    always_comb begin
        w_outcome = SCORE_MACHINE;
        if (r_player == r_mach) begin
            w_outcome = SCORE_DRAW;
        end else begin
            case ({r_player, r_mach})
                {HAND_ROCK,     HAND_SCISSORS},
                {HAND_SCISSORS, HAND_PAPER},
                {HAND_PAPER,    HAND_ROCK}:     w_outcome = SCORE_PLAYER;
                default:                        w_outcome = SCORE_MACHINE;
            endcase
        end
    end

    // Free-running machine hand source: 0,1,2,0,... every cycle.
    assign w_m_cnt_next = (r_m_cnt == 2'd2) ? 2'd0 : r_m_cnt + 2'd1;

    // Next-state logic: decide the kind of transition, then build all next values.
    always_comb begin
        w_accept  = 1'b0;
        w_to_idle = 1'b0;
        w_reveal  = 1'b0;

        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_player_next = r_player;
        w_mach_next   = r_mach;
        w_show_next   = r_show;
        w_hand_next   = r_hand;
        w_score_next  = r_score;

        case (r_state)
            ST_IDLE: begin
                // 'C' in IDLE is a no-op by design.
                if (w_is_play) w_accept = 1'b1;
            end
            ST_THINK: begin
                // Play commands are ignored while thinking; clear wins over timeout.
                if (w_is_clear)            w_to_idle = 1'b1;
                else if (r_timer == 32'd0) w_reveal  = 1'b1;
                else                       w_timer_next = r_timer - 32'd1;
            end
            ST_RESULT: begin
                // A new play restarts the round even on the timeout edge.
                if (w_is_play)                            w_accept  = 1'b1;
                else if (w_is_clear || r_timer == 32'd0)  w_to_idle = 1'b1;
                else                                      w_timer_next = r_timer - 32'd1;
            end
            default: w_to_idle = 1'b1;
        endcase

        if (w_accept) begin
            w_state_next  = ST_THINK;
            w_timer_next  = THINK_LOAD;
            w_player_next = w_play_hand;
            w_mach_next   = r_m_cnt + 2'd1;
            w_show_next   = 1'b0;
            w_hand_next   = {HAND_NONE, w_play_hand};
            w_score_next  = 2'd0;
        end else if (w_reveal) begin
            w_state_next  = ST_RESULT;
            w_timer_next  = HOLD_LOAD;
            w_show_next   = 1'b1;
            w_hand_next   = {r_mach, r_player};
            w_score_next  = w_outcome;
        end else if (w_to_idle) begin
            w_state_next  = ST_IDLE;
            w_timer_next  = 32'd0;
            w_player_next = HAND_NONE;
            w_mach_next   = HAND_NONE;
            w_show_next   = 1'b0;
            w_hand_next   = 4'd0;
            w_score_next  = 2'd0;
        end
    end

    // State, timer, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= 32'd0;
            r_m_cnt  <= 2'd0;
            r_player <= HAND_NONE;
            r_mach   <= HAND_NONE;
            r_show   <= 1'b0;
            r_hand   <= 4'd0;
            r_score  <= 2'd0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_m_cnt  <= w_m_cnt_next;
            r_player <= w_player_next;
            r_mach   <= w_mach_next;
            r_show   <= w_show_next;
            r_hand   <= w_hand_next;
            r_score  <= w_score_next;
        end
    end

    assign show  = r_show;
    assign hand  = r_hand;
    assign score = r_score;

endmodule
